// File: rtl/latency_pipe.sv
// Multi-channel programmable latency stage between port logic and a dual-port RAM core.
// Write bundles and returned read data are delayed per channel; latency changes drain first.
module latency_pipe #(
    parameter int unsigned NUM_CH     = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned MAX_LAT    = 8,
    parameter int unsigned LAT_W      = $clog2(MAX_LAT + 1),
    parameter int unsigned DEF_WR_LAT = 1,
    parameter int unsigned DEF_RD_LAT = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_CH-1:0]              i_en,
    input  logic [NUM_CH-1:0]              i_we,
    input  logic [NUM_CH*ADDR_WIDTH-1:0]   i_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_wr_din,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   i_rd_din,
    input  logic                           i_cfg_valid,
    input  logic [NUM_CH*LAT_W-1:0]        i_wr_lat,
    input  logic [NUM_CH*LAT_W-1:0]        i_rd_lat,
    output logic                           o_ready,
    output logic                           o_cfg_ready,
    output logic                           o_cfg_err,
    output logic [NUM_CH-1:0]              o_en,
    output logic [NUM_CH-1:0]              o_we,
    output logic [NUM_CH*ADDR_WIDTH-1:0]   o_addr,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_wr_din,
    output logic [NUM_CH*DATA_WIDTH-1:0]   o_rd_dout,
    output logic [NUM_CH-1:0]              o_rd_valid
);

    typedef enum logic [1:0] {StRun, StDrain, StApply} state_e;

    localparam logic [LAT_W-1:0] MaxLat   = LAT_W'(MAX_LAT);
    localparam logic [LAT_W-1:0] DefWrLat = LAT_W'(DEF_WR_LAT);
    localparam logic [LAT_W-1:0] DefRdLat = LAT_W'(DEF_RD_LAT);

    state_e state_q, state_d;

    logic [LAT_W-1:0]        wl_q [NUM_CH];
    logic [LAT_W-1:0]        wl_d [NUM_CH];
    logic [LAT_W-1:0]        rl_q [NUM_CH];
    logic [LAT_W-1:0]        rl_d [NUM_CH];
    logic [NUM_CH*LAT_W-1:0] req_wl_q, req_wl_d, req_rl_q, req_rl_d;

    logic                  en_q   [NUM_CH][MAX_LAT];
    logic                  en_d   [NUM_CH][MAX_LAT];
    logic                  we_q   [NUM_CH][MAX_LAT];
    logic                  we_d   [NUM_CH][MAX_LAT];
    logic [ADDR_WIDTH-1:0] addr_q [NUM_CH][MAX_LAT];
    logic [ADDR_WIDTH-1:0] addr_d [NUM_CH][MAX_LAT];
    logic [DATA_WIDTH-1:0] din_q  [NUM_CH][MAX_LAT];
    logic [DATA_WIDTH-1:0] din_d  [NUM_CH][MAX_LAT];
    logic [DATA_WIDTH-1:0] rd_q   [NUM_CH][MAX_LAT];
    logic [DATA_WIDTH-1:0] rd_d   [NUM_CH][MAX_LAT];
    logic                  tok_q  [NUM_CH][MAX_LAT+1];
    logic                  tok_d  [NUM_CH][MAX_LAT+1];

    logic                  ready;
    logic                  busy;
    logic                  clamp_any;
    logic [NUM_CH-1:0]     g_en;
    logic [NUM_CH-1:0]     g_we;
    logic [ADDR_WIDTH-1:0] g_addr [NUM_CH];
    logic [DATA_WIDTH-1:0] g_din  [NUM_CH];

    assign ready       = (state_q == StRun);
    assign o_ready     = ready;
    assign o_cfg_ready = (state_q == StApply);
    assign o_cfg_err   = (state_q == StApply) & clamp_any;

    // Rejected commands enter the pipe as an all-zero bundle.
    always_comb begin
        g_en = '0;
        g_we = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            g_en[c]   = i_en[c] & ready;
            g_we[c]   = g_en[c] & i_we[c];
            g_addr[c] = g_en[c] ? i_addr[c*ADDR_WIDTH +: ADDR_WIDTH] : '0;
            g_din[c]  = g_en[c] ? i_wr_din[c*DATA_WIDTH +: DATA_WIDTH] : '0;
        end
    end

    always_comb begin
        en_d   = en_q;
        we_d   = we_q;
        addr_d = addr_q;
        din_d  = din_q;
        rd_d   = rd_q;
        tok_d  = tok_q;
        for (int c = 0; c < NUM_CH; c++) begin
            en_d[c][0]   = g_en[c];
            we_d[c][0]   = g_we[c];
            addr_d[c][0] = g_addr[c];
            din_d[c][0]  = g_din[c];
            rd_d[c][0]   = i_rd_din[c*DATA_WIDTH +: DATA_WIDTH];
            tok_d[c][0]  = o_en[c] & ~o_we[c];
            for (int k = 1; k < MAX_LAT; k++) begin
                en_d[c][k]   = en_q[c][k-1];
                we_d[c][k]   = we_q[c][k-1];
                addr_d[c][k] = addr_q[c][k-1];
                din_d[c][k]  = din_q[c][k-1];
                rd_d[c][k]   = rd_q[c][k-1];
            end
            for (int k = 1; k <= MAX_LAT; k++) begin
                tok_d[c][k] = tok_q[c][k-1];
            end
        end
    end

    // Output taps: latency 0 bypasses the pipe entirely.
    always_comb begin
        o_en       = '0;
        o_we       = '0;
        o_addr     = '0;
        o_wr_din   = '0;
        o_rd_dout  = '0;
        o_rd_valid = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            o_en[c]                                = g_en[c];
            o_we[c]                                = g_we[c];
            o_addr[c*ADDR_WIDTH +: ADDR_WIDTH]     = g_addr[c];
            o_wr_din[c*DATA_WIDTH +: DATA_WIDTH]   = g_din[c];
            o_rd_dout[c*DATA_WIDTH +: DATA_WIDTH]  = i_rd_din[c*DATA_WIDTH +: DATA_WIDTH];
            o_rd_valid[c]                          = tok_q[c][0];
            for (int unsigned k = 1; k <= MAX_LAT; k++) begin
                if (wl_q[c] == LAT_W'(k)) begin
                    o_en[c]                              = en_q[c][k-1];
                    o_we[c]                              = we_q[c][k-1];
                    o_addr[c*ADDR_WIDTH +: ADDR_WIDTH]   = addr_q[c][k-1];
                    o_wr_din[c*DATA_WIDTH +: DATA_WIDTH] = din_q[c][k-1];
                end
                if (rl_q[c] == LAT_W'(k)) begin
                    o_rd_dout[c*DATA_WIDTH +: DATA_WIDTH] = rd_q[c][k-1];
                    o_rd_valid[c]                         = tok_q[c][k];
                end
            end
        end
    end

    always_comb begin
        busy = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            for (int k = 0; k < MAX_LAT; k++) begin
                busy = busy | en_q[c][k];
            end
            for (int k = 0; k <= MAX_LAT; k++) begin
                busy = busy | tok_q[c][k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        req_wl_d  = req_wl_q;
        req_rl_d  = req_rl_q;
        wl_d      = wl_q;
        rl_d      = rl_q;
        clamp_any = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (req_wl_q[c*LAT_W +: LAT_W] > MaxLat || req_rl_q[c*LAT_W +: LAT_W] > MaxLat) begin
                clamp_any = 1'b1;
            end
        end
        case (state_q)
            StRun: begin
                if (i_cfg_valid) begin
                    req_wl_d = i_wr_lat;
                    req_rl_d = i_rd_lat;
                    state_d  = StDrain;
                end
            end
            StDrain: begin
                if (!busy) begin
                    state_d = StApply;
                end
            end
            StApply: begin
                for (int c = 0; c < NUM_CH; c++) begin
                    wl_d[c] = (req_wl_q[c*LAT_W +: LAT_W] > MaxLat) ? MaxLat
                                                                     : req_wl_q[c*LAT_W +: LAT_W];
                    rl_d[c] = (req_rl_q[c*LAT_W +: LAT_W] > MaxLat) ? MaxLat
                                                                     : req_rl_q[c*LAT_W +: LAT_W];
                end
                state_d = StRun;
            end
            default: state_d = StRun;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= StRun;
            req_wl_q <= '0;
            req_rl_q <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wl_q[c] <= DefWrLat;
                rl_q[c] <= DefRdLat;
                for (int k = 0; k < MAX_LAT; k++) begin
                    en_q[c][k]   <= 1'b0;
                    we_q[c][k]   <= 1'b0;
                    addr_q[c][k] <= '0;
                    din_q[c][k]  <= '0;
                    rd_q[c][k]   <= '0;
                end
                for (int k = 0; k <= MAX_LAT; k++) begin
                    tok_q[c][k] <= 1'b0;
                end
            end
        end else begin
            state_q  <= state_d;
            req_wl_q <= req_wl_d;
            req_rl_q <= req_rl_d;
            wl_q     <= wl_d;
            rl_q     <= rl_d;
            en_q     <= en_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            din_q    <= din_d;
            rd_q     <= rd_d;
            tok_q    <= tok_d;
        end
    end

endmodule

// File: tb/tb_latency_pipe.sv
// Randomized bench for latency_pipe: a cycle-indexed event schedule predicts every output.
module tb_latency_pipe;

    localparam int NCH = 2;
    localparam int DW  = 8;
    localparam int AW  = 4;
    localparam int ML  = 8;
    localparam int LW  = 4;
    localparam int NC  = 4096;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    i_en, i_we;
    logic [NCH*AW-1:0] i_addr;
    logic [NCH*DW-1:0] i_wr_din, i_rd_din;
    logic              i_cfg_valid;
    logic [NCH*LW-1:0] i_wr_lat, i_rd_lat;
    logic              o_ready, o_cfg_ready, o_cfg_err;
    logic [NCH-1:0]    o_en, o_we, o_rd_valid;
    logic [NCH*AW-1:0] o_addr;
    logic [NCH*DW-1:0] o_wr_din, o_rd_dout;

    latency_pipe #(
        .NUM_CH(NCH), .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .MAX_LAT(ML),
        .LAT_W(LW), .DEF_WR_LAT(1), .DEF_RD_LAT(1)
    ) dut (
        .clk(clk), .rst_n(rst_n), .i_en(i_en), .i_we(i_we), .i_addr(i_addr),
        .i_wr_din(i_wr_din), .i_rd_din(i_rd_din), .i_cfg_valid(i_cfg_valid),
        .i_wr_lat(i_wr_lat), .i_rd_lat(i_rd_lat), .o_ready(o_ready),
        .o_cfg_ready(o_cfg_ready), .o_cfg_err(o_cfg_err), .o_en(o_en), .o_we(o_we),
        .o_addr(o_addr), .o_wr_din(o_wr_din), .o_rd_dout(o_rd_dout),
        .o_rd_valid(o_rd_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus for the next cycle
    logic           s_rst;
    logic [NCH-1:0] s_en, s_we;
    logic [AW-1:0]  s_addr [NCH];
    logic [DW-1:0]  s_din  [NCH];
    logic           s_cfg;
    logic [LW-1:0]  s_wl [NCH];
    logic [LW-1:0]  s_rl [NCH];
    int             force_rd;

    // Reference model: 0 run, 1 drain, 2 apply
    int      mstate;
    int      mwl [NCH];
    int      mrl [NCH];
    int      pwl [NCH];
    int      prl [NCH];
    bit      perr;
    int      last_acc [NCH];
    int      last_rdout [NCH];
    bit      exp_en   [NCH][NC];
    bit      exp_we   [NCH][NC];
    logic [AW-1:0] exp_addr [NCH][NC];
    logic [DW-1:0] exp_din  [NCH][NC];
    bit      exp_val  [NCH][NC];
    int      exp_src  [NCH][NC];
    logic [DW-1:0] rd_hist [NCH][NC];

    int n_cyc;
    int n_checks;
    int n_fail;
    bit armed;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, n_cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < NCH; c++) begin
            for (int k = n_cyc + 1; k < NC; k++) begin
                exp_en[c][k]  = 1'b0;
                exp_val[c][k] = 1'b0;
            end
            mwl[c]        = 1;
            mrl[c]        = 1;
            last_acc[c]   = -1000;
            last_rdout[c] = -1000;
        end
        mstate = 0;
        armed  = 1'b1;
    endtask

    function automatic bit model_busy(input int n);
        bit b = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (n - last_acc[c] <= ML || n - last_rdout[c] <= ML + 1) b = 1'b1;
        end
        return b;
    endfunction

    task automatic cycle();
        logic [DW-1:0] rv;
        int e, v;
        rst_n       = s_rst;
        i_cfg_valid = s_cfg;
        i_en        = s_en;
        i_we        = s_we;
        for (int c = 0; c < NCH; c++) begin
            i_addr[c*AW +: AW]   = s_addr[c];
            i_wr_din[c*DW +: DW] = s_din[c];
            i_wr_lat[c*LW +: LW] = s_wl[c];
            i_rd_lat[c*LW +: LW] = s_rl[c];
            rv = (force_rd >= 0) ? DW'(force_rd) : DW'($urandom);
            i_rd_din[c*DW +: DW] = rv;
            rd_hist[c][n_cyc]    = rv;
        end
        if (armed && s_rst && mstate == 0) begin
            for (int c = 0; c < NCH; c++) begin
                if (s_en[c]) begin
                    e = n_cyc + mwl[c];
                    exp_en[c][e]   = 1'b1;
                    exp_we[c][e]   = s_we[c];
                    exp_addr[c][e] = s_addr[c];
                    exp_din[c][e]  = s_din[c];
                    last_acc[c]    = n_cyc;
                    if (!s_we[c]) begin
                        last_rdout[c] = e;
                        v = e + 1 + mrl[c];
                        exp_val[c][v] = 1'b1;
                        exp_src[c][v] = e + 1;
                    end
                end
            end
        end
        #4;
        if (armed) begin
            check_eq("ready", 32'(o_ready), 32'(mstate == 0));
            check_eq("cfg_ready", 32'(o_cfg_ready), 32'(mstate == 2));
            check_eq("cfg_err", 32'(o_cfg_err), 32'(mstate == 2 && perr));
            for (int c = 0; c < NCH; c++) begin
                check_eq($sformatf("en%0d", c), 32'(o_en[c]), 32'(exp_en[c][n_cyc]));
                if (exp_en[c][n_cyc]) begin
                    check_eq($sformatf("we%0d", c), 32'(o_we[c]), 32'(exp_we[c][n_cyc]));
                    check_eq($sformatf("addr%0d", c), 32'(o_addr[c*AW +: AW]),
                             32'(exp_addr[c][n_cyc]));
                    check_eq($sformatf("wr_din%0d", c), 32'(o_wr_din[c*DW +: DW]),
                             32'(exp_din[c][n_cyc]));
                end
                check_eq($sformatf("rd_valid%0d", c), 32'(o_rd_valid[c]),
                         32'(exp_val[c][n_cyc]));
                if (exp_val[c][n_cyc]) begin
                    check_eq($sformatf("rd_dout%0d", c), 32'(o_rd_dout[c*DW +: DW]),
                             32'(rd_hist[c][exp_src[c][n_cyc]]));
                end
            end
        end
        @(posedge clk);
        #1;
        if (!s_rst) begin
            model_reset();
        end else begin
            case (mstate)
                0: if (s_cfg) begin
                    perr = 1'b0;
                    for (int c = 0; c < NCH; c++) begin
                        pwl[c] = int'(s_wl[c]);
                        prl[c] = int'(s_rl[c]);
                        if (pwl[c] > ML || prl[c] > ML) perr = 1'b1;
                    end
                    mstate = 1;
                end
                1: if (!model_busy(n_cyc)) mstate = 2;
                default: begin
                    for (int c = 0; c < NCH; c++) begin
                        mwl[c] = (pwl[c] > ML) ? ML : pwl[c];
                        mrl[c] = (prl[c] > ML) ? ML : prl[c];
                    end
                    mstate = 0;
                end
            endcase
        end
        n_cyc++;
        force_rd = -1;
    endtask

    task automatic rand_stim(input int unsigned pct);
        for (int c = 0; c < NCH; c++) begin
            s_en[c]   = ($urandom_range(99) < pct);
            s_we[c]   = 1'($urandom_range(1));
            s_addr[c] = AW'($urandom);
            s_din[c]  = DW'($urandom);
        end
    endtask

    task automatic run_rand(input int ncyc, input int unsigned pct);
        for (int i = 0; i < ncyc; i++) begin
            rand_stim(pct);
            s_cfg = 1'b0;
            cycle();
        end
    endtask

    task automatic reconfig(input int w0, input int r0, input int w1, input int r1);
        int guard;
        s_wl[0] = LW'(w0);
        s_rl[0] = LW'(r0);
        s_wl[1] = LW'(w1);
        s_rl[1] = LW'(r1);
        rand_stim(60);
        s_cfg = 1'b1;
        cycle();
        s_cfg = 1'b0;
        guard = 0;
        while (mstate != 0 && guard < 100) begin
            rand_stim(60);
            cycle();
            guard++;
        end
    endtask

    initial begin
        n_cyc = 0; n_checks = 0; n_fail = 0; armed = 1'b0; force_rd = -1;
        mstate = 0; perr = 1'b0;
        s_rst = 1'b0; s_en = '0; s_we = '0; s_cfg = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            s_addr[c] = '0; s_din[c] = '0; s_wl[c] = '0; s_rl[c] = '0;
            pwl[c] = 0; prl[c] = 0;
        end
        rst_n = 1'b0; i_en = '0; i_we = '0; i_addr = '0; i_wr_din = '0; i_rd_din = '0;
        i_cfg_valid = 1'b0; i_wr_lat = '0; i_rd_lat = '0;
        @(posedge clk);
        #1;

        // Two reset cycles, then the reset-state read data must be clear
        cycle();
        cycle();
        check_eq("rst_rd_dout", 32'(o_rd_dout), 32'h0);
        s_rst = 1'b1;

        // Directed write ch0 addr 3 data A5
        s_en = 2'b01; s_we = 2'b01; s_addr[0] = 4'd3; s_din[0] = 8'hA5;
        cycle();
        s_en = '0;
        repeat (4) cycle();

        run_rand(150, 70);

        // Pass-through on ch1: read addr 7, RAM answers 0x3C the next cycle
        reconfig(1, 1, 0, 0);
        s_en = '0;
        repeat (3) cycle();
        s_en = 2'b10; s_we = 2'b00; s_addr[1] = 4'd7;
        cycle();
        s_en = '0;
        force_rd = 8'h3C;
        cycle();
        repeat (3) cycle();

        // Maximum latency, ten back-to-back reads on ch0
        reconfig(8, 8, 8, 8);
        s_en = '0;
        repeat (2) cycle();
        for (int i = 0; i < 10; i++) begin
            s_en = 2'b01; s_we = 2'b00; s_addr[0] = AW'(i);
            cycle();
        end
        s_en = '0;
        repeat (25) cycle();

        // Reconfigure while reads are in flight
        run_rand(20, 90);
        reconfig(3, 5, 6, 2);
        run_rand(40, 80);

        // Clamping of oversized requests
        reconfig(12, 1, 2, 15);
        run_rand(40, 70);

        for (int r = 0; r < 12; r++) begin
            reconfig($urandom_range(15), $urandom_range(15), $urandom_range(15),
                     $urandom_range(15));
            run_rand(50, $urandom_range(100));
        end

        // Reset in the middle of a drain
        reconfig(8, 8, 8, 8);
        run_rand(10, 95);
        s_wl[0] = 4'd2; s_rl[0] = 4'd2; s_wl[1] = 4'd2; s_rl[1] = 4'd2;
        s_en = '0; s_cfg = 1'b1;
        cycle();
        s_cfg = 1'b0;
        repeat (3) cycle();
        check_eq("drain_before_rst", 32'(o_ready), 32'h0);
        s_rst = 1'b0;
        cycle();
        s_rst = 1'b1;
        run_rand(60, 70);
        s_en = '0;
        repeat (20) cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
